aquaflex_flow_sequencer: RTL

- Control-layer sequencer for the aquaflex-5a fluidic netlist: the five-input switch tree, load pump, mixer, unload pump and five-output switch tree.
- Accepts one transfer command at a time and drives every valve needed to carry it out:
  - opens the selected inlet path, then strokes the load pump;
  - runs the mixer peristaltically;
  - opens the selected outlet path, then strokes the unload pump.
- Sits between the host command interface and the off-chip pneumatic valve drivers.

---
 rtl/aquaflex_flow_sequencer_if.sv | 30 +++
 rtl/aquaflex_flow_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aquaflex_flow_sequencer_if.sv
// Host command handshake plus valve-driver outputs of the aquaflex-5a flow sequencer.
interface aquaflex_flow_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_src;
  logic [2:0]       cmd_dst;
  logic [CNT_W-1:0] cmd_vol;
  logic [CNT_W-1:0] cmd_mix;
  logic             abort;
  logic [4:0]       in_sel;
  logic [4:0]       out_sel;
  logic [2:0]       pa_v;
  logic [2:0]       pc_v;
  logic [2:0]       mx_v;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_src, cmd_dst, cmd_vol, cmd_mix, abort,
    input  cmd_ready, in_sel, out_sel, pa_v, pc_v, mx_v, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst, cmd_vol, cmd_mix, abort,
    output cmd_ready, in_sel, out_sel, pa_v, pc_v, mx_v, busy, done, err
  );
endinterface

// File: rtl/aquaflex_flow_sequencer.sv
// Transfer sequencer for the aquaflex-5a switch trees, load/unload pumps and mixer.
// Defining AQUAFLEX_STATUS_CNT_EN adds the op_count / abort_count status outputs.
module aquaflex_flow_sequencer #(
  parameter int PHASE_CYC  = 8,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  aquaflex_flow_sequencer_if.slave bus
`ifdef AQUAFLEX_STATUS_CNT_EN
  ,
  output logic [15:0] op_count,
  output logic [7:0]  abort_count
`endif
);

  localparam int TMR_MAX = (PHASE_CYC > SETTLE_CYC) ? PHASE_CYC : SETTLE_CYC;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] PHASE_LD  = TMR_W'(PHASE_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [2:0] CLOSED = 3'b111;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ROUTE_IN  = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_MIX       = 3'd3;
  localparam logic [2:0] S_ROUTE_OUT = 3'd4;
  localparam logic [2:0] S_UNLOAD    = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  // Peristaltic valve pattern for step 0..5 of one stroke (1 = closed).
  function automatic logic [2:0] step_pattern(input logic [2:0] step);
    case (step)
      3'd0:    step_pattern = 3'b100;
      3'd1:    step_pattern = 3'b110;
      3'd2:    step_pattern = 3'b010;
      3'd3:    step_pattern = 3'b011;
      3'd4:    step_pattern = 3'b001;
      3'd5:    step_pattern = 3'b101;
      default: step_pattern = CLOSED;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       step_q, step_d;
  logic [CNT_W-1:0] stroke_q, stroke_d;
  logic [2:0]       src_q, src_d, dst_q, dst_d;
  logic [CNT_W-1:0] vol_q, vol_d, mix_q, mix_d;
  logic [4:0]       in_sel_q, in_sel_d, out_sel_q, out_sel_d;
  logic [2:0]       pa_v_q, pa_v_d, pc_v_q, pc_v_d, mx_v_q, mx_v_d;
  logic             done_q, done_d, err_q, err_d;

  logic             accept, bad_cmd, abort_hit, tmr_zero, pump_end;
  logic [CNT_W-1:0] pump_cnt;

  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  assign bad_cmd   = (bus.cmd_src > 3'd4) || (bus.cmd_dst > 3'd4);
  assign abort_hit = bus.abort && (state_q != S_IDLE);
  assign tmr_zero  = (tmr_q == '0);
  assign pump_cnt  = (state_q == S_MIX) ? mix_q : vol_q;
  // Pump states are only entered with a nonzero count, so count-1 never wraps.
  assign pump_end  = tmr_zero && (step_q == 3'd5) && (stroke_q == pump_cnt - CNT_W'(1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    tmr_d    = tmr_q;
    step_d   = step_q;
    stroke_d = stroke_q;
    src_d    = src_q;
    dst_d    = dst_q;
    vol_d    = vol_q;
    mix_d    = mix_q;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: if (accept) begin
        src_d = bus.cmd_src;
        dst_d = bus.cmd_dst;
        vol_d = bus.cmd_vol;
        mix_d = bus.cmd_mix;
        if (bad_cmd) err_d = 1'b1;
        else         state_d = S_ROUTE_IN;
      end
      S_ROUTE_IN: if (tmr_zero)
        state_d = (vol_q != '0) ? S_LOAD : ((mix_q != '0) ? S_MIX : S_ROUTE_OUT);
      S_LOAD: if (pump_end)
        state_d = (mix_q != '0) ? S_MIX : S_ROUTE_OUT;
      S_MIX: if (pump_end)
        state_d = S_ROUTE_OUT;
      S_ROUTE_OUT: if (tmr_zero)
        state_d = (vol_q != '0) ? S_UNLOAD : S_DONE;
      S_UNLOAD: if (pump_end)
        state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_hit) state_d = S_IDLE;

    // Entering any state restarts its timing from step 0 of stroke 0.
    if (state_d != state_q) begin
      tmr_d    = ((state_d == S_ROUTE_IN) || (state_d == S_ROUTE_OUT)) ? SETTLE_LD : PHASE_LD;
      step_d   = 3'd0;
      stroke_d = '0;
    end else if (!tmr_zero) begin
      tmr_d = tmr_q - TMR_W'(1);
    end else if ((state_q == S_LOAD) || (state_q == S_MIX) || (state_q == S_UNLOAD)) begin
      tmr_d = PHASE_LD;
      if (step_q == 3'd5) begin
        step_d   = 3'd0;
        stroke_d = stroke_q + CNT_W'(1);
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // Valve drives are decoded from the current state and registered, giving glitch-free pneumatic outputs.
  always_comb begin
    in_sel_d  = '0;
    out_sel_d = '0;
    pa_v_d    = CLOSED;
    pc_v_d    = CLOSED;
    mx_v_d    = CLOSED;
    done_d    = (state_q == S_DONE);
    case (state_q)
      S_ROUTE_IN:  in_sel_d = 5'b00001 << src_q;
      S_LOAD: begin
        in_sel_d = 5'b00001 << src_q;
        pa_v_d   = step_pattern(step_q);
      end
      S_MIX:       mx_v_d = step_pattern(step_q);
      S_ROUTE_OUT: out_sel_d = 5'b00001 << dst_q;
      S_UNLOAD: begin
        out_sel_d = 5'b00001 << dst_q;
        pc_v_d    = step_pattern(step_q);
      end
      default: ;
    endcase
    if (abort_hit) begin
      in_sel_d  = '0;
      out_sel_d = '0;
      pa_v_d    = CLOSED;
      pc_v_d    = CLOSED;
      mx_v_d    = CLOSED;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      step_q    <= '0;
      stroke_q  <= '0;
      // NOTE: the latched command fields are plain registers, so resetting them is cheap and keeps state deterministic.
      src_q     <= '0;
      dst_q     <= '0;
      vol_q     <= '0;
      mix_q     <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      pa_v_q    <= CLOSED;
      pc_v_q    <= CLOSED;
      mx_v_q    <= CLOSED;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      step_q    <= step_d;
      stroke_q  <= stroke_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      vol_q     <= vol_d;
      mix_q     <= mix_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      pa_v_q    <= pa_v_d;
      pc_v_q    <= pc_v_d;
      mx_v_q    <= mx_v_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_sel    = in_sel_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.pa_v      = pa_v_q;
  assign bus.pc_v      = pc_v_q;
  assign bus.mx_v      = mx_v_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef AQUAFLEX_STATUS_CNT_EN
  logic [15:0] op_count_q, op_count_d;
  logic [7:0]  abort_count_q, abort_count_d;

  always_comb begin
    op_count_d    = op_count_q;
    abort_count_d = abort_count_q;
    if (done_q && (op_count_q != 16'hFFFF))     op_count_d    = op_count_q + 16'd1;
    if (abort_hit && (abort_count_q != 8'hFF))  abort_count_d = abort_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q    <= '0;
      abort_count_q <= '0;
    end else begin
      op_count_q    <= op_count_d;
      abort_count_q <= abort_count_d;
    end
  end

  assign op_count    = op_count_q;
  assign abort_count = abort_count_q;
`endif

endmodule
